alu_seq_core: RTL and testbench
===============================

Name: alu_seq_core

Overview:
- Parametrised successor to the board-level 8-bit ALU datapath: owns the operand A/B registers and the result register Y.
- Adds a start/busy/done handshake, iterative multi-cycle multiply/divide and status flags.
- Sits between the switch/button front end and the display/LED logic.
- Runs on the divided clock domain; one clock, no internal CDC.

Parameters:
- WIDTH, 8: operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1: iteration counter width. Derived; not to be overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  operand data.
- load_a  input  1  capture data_in into A.
- load_b  input  1  capture data_in into B.
- op  input  4  operation select, sampled on start.
- start  input  1  single-cycle request to execute op.
- busy  output  1  high while a multi-cycle op iterates.
- done  output  1  one-cycle pulse when Y and flags update.
- y  output  WIDTH  result register.
- a_out  output  WIDTH  A register (drives LEDs).
- b_out  output  WIDTH  B register.
- flag_zero, flag_carry, flag_ovf, flag_dz  output  1 each  status flags.

Behaviour:
- Reset (asynchronous, active-high) clears A, B, y, all flags, busy, done and the counter, and forces state IDLE. A reset mid-iteration aborts the op: no done pulse, y stays 0.
- Opcodes (unsigned unless stated):
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A
  - 6 SHL A by 1, 7 SHR A by 1 (logical)
  - 8 MUL (low WIDTH bits), 9 DIV (quotient), 10 MOD (remainder)
  - 11 INC A, 12 DEC A, 13 SLT (y=1 if A<B else 0), 14 PASS B, 15 MIN(A,B)
- States:
  - IDLE: start with op in {8,9,10} and B!=0 (or op=8) -> latch op/A/B, counter=WIDTH -> ITER. Any other start -> compute and update y/flags on that edge, done=1 on the next cycle (latency 1).
  - ITER: busy=1. MUL runs shift-add, DIV/MOD run restoring division, one bit per cycle; counter decrements each cycle. At counter==1, write y/flags, pulse done, return to IDLE. Total: start edge to done is WIDTH+1 cycles; busy is high for WIDTH cycles.
- DIV/MOD with B==0: single-cycle. y = all-ones (DIV) or A (MOD), flag_dz=1, done after 1 cycle.
- Flags update only when done pulses and hold otherwise.
  - flag_zero = (y==0).
  - flag_carry: carry-out (ADD, INC); borrow (SUB, DEC); shifted-out bit (SHL, SHR); 0 otherwise.
  - flag_ovf: signed overflow for ADD/SUB/INC/DEC; for MUL, high WIDTH bits of product nonzero; 0 otherwise.
  - flag_dz: 1 only for DIV/MOD by zero.
- Precedence:
  - start while busy is ignored, with no effect on the running op.
  - load_a/load_b while busy or in the same cycle as start are ignored.
  - load_a and load_b together in IDLE load both registers with data_in.
- Wrap-around: ADD/SUB/INC/DEC/MUL results are modulo 2^WIDTH.
- done is never asserted while busy is high except on the final ITER cycle.

Optional Feature:
- Macro: ALU_ACC_CHAIN_EN.
- Defined: on every done pulse with flag_dz=0, A is also loaded with the new y, giving accumulator-style chaining (e.g. repeated INC counts). The load_a port keeps priority over chaining only in IDLE cycles without done.
- Undefined: A changes only via load_a or reset.

Test Plan:
- WIDTH=8; load A=0xFF, B=0x01; start op=0 -> one cycle later y=0x00, done=1, flag_zero=1, flag_carry=1, flag_ovf=0.
- A=0x7F, B=0x01, op=0 -> y=0x80, flag_ovf=1, flag_carry=0. Then op=1 with A=0x03, B=0x05 -> y=0xFE, flag_carry=1.
- A=0x0D, B=0x0B, op=8 -> busy high 8 cycles, done at cycle 9, y=0x8F, flag_ovf=0. A=0x20, B=0x10, op=8 -> y=0x00, flag_ovf=1, flag_zero=1.
- A=0x64, B=0x07: op=9 -> y=0x0E after 9 cycles; op=10 -> y=0x02. B=0x00, op=9 -> y=0xFF, flag_dz=1, done after 1 cycle.
- During MUL iteration, pulse start (op=0) and load_a=1 -> ignored; MUL result unchanged, A unchanged. Assert reset at cycle 4 of ITER -> busy=0, y=0, no done pulse.
- ALU_ACC_CHAIN_EN defined: A=0x00, three starts of op=11 -> y=0x01, 0x02, 0x03 and a_out tracks y. Undefined -> y=0x01 each time.

Source files
------------

// File: rtl/alu_seq_core_if.sv
// Operand/result bus of alu_seq_core: operand loads, start/busy/done handshake,
// result and status flags. master = front end, slave = the core.
interface alu_seq_core_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_a;
  logic             load_b;
  logic [3:0]       op;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_ovf;
  logic             flag_dz;

  modport master (
    output data_in, load_a, load_b, op, start,
    input  busy, done, y, a_out, b_out, flag_zero, flag_carry, flag_ovf, flag_dz
  );

  modport slave (
    input  data_in, load_a, load_b, op, start,
    output busy, done, y, a_out, b_out, flag_zero, flag_carry, flag_ovf, flag_dz
  );
endinterface

// File: rtl/alu_seq_core.sv
// Sequential ALU: A/B/Y registers, single-cycle ops plus iterative MUL/DIV/MOD.
// Define ALU_ACC_CHAIN_EN to reload A with every non-divide-by-zero result.
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input logic           clock,
  input logic           reset,
  alu_seq_core_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int MSB   = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_NOT = 4'd5,  OP_SHL = 4'd6,  OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8,  OP_DIV = 4'd9,  OP_MOD = 4'd10, OP_INC = 4'd11;
  localparam logic [3:0] OP_DEC = 4'd12, OP_SLT = 4'd13, OP_PSB = 4'd14, OP_MIN = 4'd15;

  typedef enum logic {IDLE, ITER} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a, b, y_r, hi, lo;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic             done_r, fz, fc, fv, fd;
  logic             go_iter, go_single, finish;

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] s_res;
  logic             s_c, s_v, s_dz;

  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] nxt_hi, nxt_lo, it_res;
  logic             it_ovf;

  assign bus.a_out      = a;
  assign bus.b_out      = b;
  assign bus.y          = y_r;
  assign bus.done       = done_r;
  assign bus.busy       = (state == ITER);
  assign bus.flag_zero  = fz;
  assign bus.flag_carry = fc;
  assign bus.flag_ovf   = fv;
  assign bus.flag_dz    = fd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go_iter   = 1'b0;
    go_single = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        if (bus.op == OP_MUL || ((bus.op == OP_DIV || bus.op == OP_MOD) && b != '0)) begin
          go_iter   = 1'b1;
          state_nxt = ITER;
        end else begin
          go_single = 1'b1;
        end
      end
      ITER: if (cnt == CNT_W'(1)) begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle result; DIV/MOD only reach here with B == 0.
  always_comb begin
    ext   = '0;
    s_res = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    s_dz  = 1'b0;
    case (bus.op)
      OP_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        s_res = ext[MSB:0];
        s_c   = ext[WIDTH];
        s_v   = (a[MSB] == b[MSB]) && (s_res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        ext   = {1'b0, a} - {1'b0, b};
        s_res = ext[MSB:0];
        s_c   = ext[WIDTH];
        s_v   = (a[MSB] != b[MSB]) && (s_res[MSB] != a[MSB]);
      end
      OP_AND: s_res = a & b;
      OP_OR:  s_res = a | b;
      OP_XOR: s_res = a ^ b;
      OP_NOT: s_res = ~a;
      OP_SHL: begin s_res = {a[MSB-1:0], 1'b0}; s_c = a[MSB]; end
      OP_SHR: begin s_res = {1'b0, a[MSB:1]};   s_c = a[0];   end
      OP_DIV: begin s_res = '1; s_dz = 1'b1; end
      OP_MOD: begin s_res = a;  s_dz = 1'b1; end
      OP_INC: begin
        ext   = {1'b0, a} + (WIDTH+1)'(1);
        s_res = ext[MSB:0];
        s_c   = ext[WIDTH];
        s_v   = ~a[MSB] & s_res[MSB];
      end
      OP_DEC: begin
        ext   = {1'b0, a} - (WIDTH+1)'(1);
        s_res = ext[MSB:0];
        s_c   = ext[WIDTH];
        s_v   = a[MSB] & ~s_res[MSB];
      end
      OP_SLT: s_res = WIDTH'(a < b);
      OP_PSB: s_res = b;
      OP_MIN: s_res = (a < b) ? a : b;
      default: s_res = '0;
    endcase
  end

  // One bit per cycle. MUL: {hi,lo} is the product with the multiplier shifting
  // out of lo. DIV/MOD: hi is the partial remainder, lo the dividend/quotient.
  // A and B cannot change during ITER, so they serve as the latched operands.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
    div_shift = {hi, lo[MSB]};
    div_diff  = div_shift - {1'b0, b};
    if (op_q == OP_MUL) begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], lo[MSB:1]};
    end else if (!div_diff[WIDTH]) begin
      nxt_hi = div_diff[MSB:0];
      nxt_lo = {lo[MSB-1:0], 1'b1};
    end else begin
      nxt_hi = div_shift[MSB:0];
      nxt_lo = {lo[MSB-1:0], 1'b0};
    end
    it_res = (op_q == OP_MOD) ? nxt_hi : nxt_lo;
    it_ovf = (op_q == OP_MUL) && (nxt_hi != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a      <= '0;
      b      <= '0;
      y_r    <= '0;
      hi     <= '0;
      lo     <= '0;
      op_q   <= '0;
      cnt    <= '0;
      done_r <= 1'b0;
      fz     <= 1'b0;
      fc     <= 1'b0;
      fv     <= 1'b0;
      fd     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE && !bus.start) begin
        if (bus.load_a) a <= bus.data_in;
        if (bus.load_b) b <= bus.data_in;
      end
      if (go_single) begin
        y_r    <= s_res;
        fz     <= (s_res == '0);
        fc     <= s_c;
        fv     <= s_v;
        fd     <= s_dz;
        done_r <= 1'b1;
`ifdef ALU_ACC_CHAIN_EN
        if (!s_dz) a <= s_res;
`endif
      end
      if (go_iter) begin
        op_q <= bus.op;
        cnt  <= CNT_W'(WIDTH);
        hi   <= '0;
        lo   <= (bus.op == OP_MUL) ? b : a;
      end
      if (state == ITER) begin
        hi  <= nxt_hi;
        lo  <= nxt_lo;
        cnt <= cnt - CNT_W'(1);
        if (finish) begin
          y_r    <= it_res;
          fz     <= (it_res == '0);
          fc     <= 1'b0;
          fv     <= it_ovf;
          fd     <= 1'b0;
          done_r <= 1'b1;
`ifdef ALU_ACC_CHAIN_EN
          a <= it_res;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_core.sv
// Randomized self-checking bench for alu_seq_core against an arithmetic reference
// model; honours ALU_ACC_CHAIN_EN when defined.
module tb_alu_seq_core;
  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));
`ifdef ALU_ACC_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] y;
    logic [3:0] f;    // {zero, carry, ovf, dz}
    logic [3:0] lat;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ma = 0, mb = 0;

  alu_seq_core_if #(.WIDTH(W)) bus();
  alu_seq_core #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  function automatic void model(input int op, input int a, input int b,
                                output int y, output logic [3:0] f);
    int sa, sb, r;
    bit c, v, dz;
    sa = (a > SMAX) ? a - (MASK + 1) : a;
    sb = (b > SMAX) ? b - (MASK + 1) : b;
    r = 0; c = 0; v = 0; dz = 0;
    case (op)
      0:  begin r = a + b; c = r > MASK; v = (sa + sb > SMAX) || (sa + sb < SMIN); end
      1:  begin r = a - b; c = a < b;    v = (sa - sb > SMAX) || (sa - sb < SMIN); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~a;
      6:  begin r = a * 2; c = a > SMAX; end
      7:  begin r = a / 2; c = (a % 2) == 1; end
      8:  begin r = a * b; v = r > MASK; end
      9:  if (b == 0) begin r = MASK; dz = 1; end else r = a / b;
      10: if (b == 0) begin r = a;    dz = 1; end else r = a % b;
      11: begin r = a + 1; c = r > MASK; v = sa + 1 > SMAX; end
      12: begin r = a - 1; c = a == 0;   v = sa - 1 < SMIN; end
      13: r = (a < b) ? 1 : 0;
      14: r = b;
      default: r = (a < b) ? a : b;
    endcase
    y = r & MASK;
    f = {y == 0, c, v, dz};
  endfunction

  function automatic bool_iter(input int op, input int b);
    return (op == 8) || ((op == 9 || op == 10) && b != 0);
  endfunction

  function automatic int pick();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return MASK;
      2: return SMAX;
      3: return SMAX + 1;
      default: return int'($urandom_range(0, MASK));
    endcase
  endfunction

  task automatic apply_chain(input int y, input logic [3:0] f);
    if (CHAIN && !f[0]) ma = y;
  endtask

  task automatic load_ab(input int a, input int b);
    @(negedge clock); bus.data_in = W'(a); bus.load_a = 1'b1;
    @(negedge clock); bus.load_a = 1'b0; bus.data_in = W'(b); bus.load_b = 1'b1;
    @(negedge clock); bus.load_b = 1'b0;
    ma = a; mb = b;
  endtask

  // Pulse start, wait (bounded) for done, return observations.
  task automatic exec(input logic [3:0] op, output logic [7:0] y, output logic [3:0] f,
                      output int lat, output int busy_n, output bit overlap,
                      output logic done_after);
    @(negedge clock); bus.op = op; bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    lat = 1; busy_n = 0; overlap = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_n++;
      @(negedge clock); lat++;
    end
    if (bus.busy === 1'b1) busy_n++;
    if (bus.busy === 1'b1 && bus.done === 1'b1) overlap = 1;
    y = bus.y;
    f = {bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_dz};
    @(negedge clock); done_after = bus.done;
  endtask

  task automatic test_reset();
    bus.data_in = '0; bus.load_a = 0; bus.load_b = 0; bus.op = '0; bus.start = 0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_tests++; if (bus.y !== 8'h00) begin n_fail++; $display("FAIL reset_y got %h exp 00", bus.y); end
    n_tests++; if (bus.a_out !== 8'h00 || bus.b_out !== 8'h00) begin n_fail++; $display("FAIL reset_ab got %h/%h exp 00/00", bus.a_out, bus.b_out); end
    n_tests++; if ({bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_dz} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_dz}); end
    n_tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_hs got busy=%b done=%b exp 0/0", bus.busy, bus.done); end
    reset = 1'b0;
  endtask

  task automatic test_plan_vectors();
    vec_t vecs [9];
    logic [7:0] y; logic [3:0] f; int lat, bn; bit ov; logic da;
    vecs = '{'{8'hFF, 8'h01, 4'd0,  8'h00, 4'b1100, 4'd1},
             '{8'h7F, 8'h01, 4'd0,  8'h80, 4'b0010, 4'd1},
             '{8'h03, 8'h05, 4'd1,  8'hFE, 4'b0100, 4'd1},
             '{8'h0D, 8'h0B, 4'd8,  8'h8F, 4'b0000, 4'd9},
             '{8'h20, 8'h10, 4'd8,  8'h00, 4'b1010, 4'd9},
             '{8'h64, 8'h07, 4'd9,  8'h0E, 4'b0000, 4'd9},
             '{8'h64, 8'h07, 4'd10, 8'h02, 4'b0000, 4'd9},
             '{8'h64, 8'h00, 4'd9,  8'hFF, 4'b0001, 4'd1},
             '{8'h64, 8'h00, 4'd10, 8'h64, 4'b0001, 4'd1}};
    foreach (vecs[i]) begin
      load_ab(int'(vecs[i].a), int'(vecs[i].b));
      exec(vecs[i].op, y, f, lat, bn, ov, da);
      n_tests++; if (y !== vecs[i].y) begin n_fail++; $display("FAIL vec%0d_y got %h exp %h", i, y, vecs[i].y); end
      n_tests++; if (f !== vecs[i].f) begin n_fail++; $display("FAIL vec%0d_flags got %b exp %b", i, f, vecs[i].f); end
      n_tests++; if (lat != int'(vecs[i].lat)) begin n_fail++; $display("FAIL vec%0d_latency got %0d exp %0d", i, lat, vecs[i].lat); end
      n_tests++; if (bn != ((vecs[i].lat == 4'd9) ? 8 : 0)) begin n_fail++; $display("FAIL vec%0d_busy_cycles got %0d", i, bn); end
      n_tests++; if (ov || da !== 1'b0) begin n_fail++; $display("FAIL vec%0d_done_pulse overlap=%0d done_after=%b exp 0/0", i, ov, da); end
      apply_chain(int'(y), f);
    end
  endtask

  task automatic test_random(input int n, input bit muldiv);
    logic [7:0] y; logic [3:0] f, ef; int lat, bn, op, a, b, ey, elat; bit ov; logic da;
    for (int i = 0; i < n; i++) begin
      op = muldiv ? int'($urandom_range(8, 10)) : int'($urandom_range(0, 15));
      a = pick(); b = pick();
      load_ab(a, b);
      model(op, a, b, ey, ef);
      elat = bool_iter(op, b) ? W + 1 : 1;
      exec(4'(op), y, f, lat, bn, ov, da);
      apply_chain(ey, ef);
      n_tests++; if (int'(y) != ey) begin n_fail++; $display("FAIL rand_y op=%0d a=%h b=%h got %h exp %h", op, a, b, y, ey); end
      n_tests++; if (f !== ef) begin n_fail++; $display("FAIL rand_flags op=%0d a=%h b=%h got %b exp %b", op, a, b, f, ef); end
      n_tests++; if (lat != elat || bn != elat - 1 || ov) begin n_fail++; $display("FAIL rand_timing op=%0d got lat=%0d busy=%0d exp lat=%0d busy=%0d", op, lat, bn, elat, elat - 1); end
      n_tests++; if (int'(bus.a_out) != ma || int'(bus.b_out) != mb) begin n_fail++; $display("FAIL rand_regs got %h/%h exp %h/%h", bus.a_out, bus.b_out, ma, mb); end
    end
  endtask

  task automatic test_load_precedence();
    int x, z;
    x = int'($urandom_range(0, MASK)); z = x ^ 8'h5A;
    @(negedge clock); bus.data_in = W'(x); bus.load_a = 1; bus.load_b = 1;
    @(negedge clock); bus.load_a = 0; bus.load_b = 0;
    ma = x; mb = x;
    n_tests++; if (int'(bus.a_out) != x || int'(bus.b_out) != x) begin n_fail++; $display("FAIL load_both got %h/%h exp %h", bus.a_out, bus.b_out, x); end
    bus.op = 4'd14; bus.start = 1; bus.load_b = 1; bus.data_in = W'(z);
    @(negedge clock); bus.start = 0; bus.load_b = 0;
    n_tests++; if (bus.done !== 1'b1 || int'(bus.y) != x) begin n_fail++; $display("FAIL load_with_start got done=%b y=%h exp 1/%h", bus.done, bus.y, x); end
    n_tests++; if (int'(bus.b_out) != x) begin n_fail++; $display("FAIL load_with_start_b got %h exp %h", bus.b_out, x); end
    @(negedge clock);
  endtask

  task automatic test_busy_ignore();
    int lat; logic [3:0] f;
    load_ab(8'h0D, 8'h0B);
    @(negedge clock); bus.op = 4'd8; bus.start = 1;
    @(negedge clock); bus.start = 0;
    repeat (2) @(negedge clock);
    bus.op = 4'd0; bus.start = 1; bus.load_a = 1; bus.data_in = 8'h55;
    @(negedge clock); bus.start = 0; bus.load_a = 0;
    n_tests++; if (bus.a_out !== 8'h0D || bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_ignore_a got a=%h busy=%b exp 0d/1", bus.a_out, bus.busy); end
    lat = 4;
    while (bus.done !== 1'b1 && lat < 40) begin @(negedge clock); lat++; end
    f = {bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.flag_dz};
    n_tests++; if (lat != 9 || bus.y !== 8'h8F || f !== 4'b0000) begin n_fail++; $display("FAIL busy_ignore_mul got lat=%0d y=%h f=%b exp 9/8f/0000", lat, bus.y, f); end
    apply_chain(8'h8F, f);
    @(negedge clock);
    n_tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || int'(bus.a_out) != ma) begin n_fail++; $display("FAIL busy_ignore_after got done=%b busy=%b a=%h exp 0/0/%h", bus.done, bus.busy, bus.a_out, ma); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    load_ab(8'h0D, 8'h0B);
    @(negedge clock); bus.op = 4'd8; bus.start = 1;
    @(negedge clock); bus.start = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1; #1;
    n_tests++; if (bus.busy !== 1'b0 || bus.y !== 8'h00 || bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_mid got busy=%b y=%h done=%b exp 0/00/0", bus.busy, bus.y, bus.done); end
    @(negedge clock); reset = 1'b0;
    ma = 0; mb = 0; seen = 0;
    repeat (12) begin @(negedge clock); if (bus.done === 1'b1) seen = 1; end
    n_tests++; if (seen || bus.y !== 8'h00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_after got done_seen=%0d y=%h busy=%b exp 0/00/0", seen, bus.y, bus.busy); end
  endtask

  task automatic test_chain();
    logic [7:0] y; logic [3:0] f; int lat, bn, ey, ea; bit ov; logic da;
    load_ab(8'h00, int'($urandom_range(0, MASK)));
    for (int k = 1; k <= 3; k++) begin
      exec(4'd11, y, f, lat, bn, ov, da);
      ey = CHAIN ? k : 1;
      ea = CHAIN ? k : 0;
      n_tests++; if (int'(y) != ey) begin n_fail++; $display("FAIL chain_inc%0d_y got %h exp %h", k, y, ey); end
      n_tests++; if (int'(bus.a_out) != ea) begin n_fail++; $display("FAIL chain_inc%0d_a got %h exp %h", k, bus.a_out, ea); end
    end
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_random(60, 1'b0);
    test_random(20, 1'b1);
    test_load_precedence();
    test_busy_ignore();
    test_reset_mid();
    test_chain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
